// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame
// header size and byte-lane geometry of an assembled instruction word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_N   = 3'd1,
        HDR_S   = 3'd2,
        DATA    = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5,
        ERR     = 3'd6
    } state_t;

    // Header is the word count N followed by the start address S.
    localparam int HDR_BYTES  = 8;

    localparam int BYTE_W     = 8;
    localparam int WORD_LANES = 4;
    localparam int WORD_W     = BYTE_W * WORD_LANES;
    localparam int LANE_IDX_W = $clog2(WORD_LANES);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(WORD_LANES - 1);

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian word assembler: collects four bytes into a 32-bit word.
// The word including the byte being shifted in this cycle is presented
// combinationally, so the owner can act on the 4th byte at the same edge.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    logic [LANE_IDX_W-1:0] lane_q;
    logic [WORD_W-1:0]     shreg_q;

    // Bytes enter at the top so the first byte ends up in the low lane.
    assign word      = {byte_in, shreg_q[WORD_W-1:BYTE_W]};
    assign word_done = shift_en && (lane_q == LAST_LANE);

    // Lane counter and shift register; the counter wraps after each word.
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else if (shift_en) begin
            lane_q  <= lane_q + 1'b1;
            shreg_q <= word;
        end else if (clear) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot/reload loader: parses a framed byte stream (N, S, N words), writes the
// words to instruction memory while the pipeline is frozen, then redirects
// the PC to S with a one-cycle branch+flush pulse. Every output is a register
// loaded from the next state, so outputs line up with the state they belong to.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        freeze,
    output logic        flush,
    output logic        branchTaken,
    output logic [31:0] branchAddress,
    output logic        busy,
    output logic        error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t            state_q, state_d;
    logic              accept;
    logic              in_frame;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_next;
    logic [31:0]       s_q;
    logic              frame_busy;

    assign accept     = byte_valid && byte_ready;
    assign in_frame   = (state_q == HDR_N) || (state_q == HDR_S) || (state_q == DATA);
    assign idx_next   = idx_q + IDX_W'(1);
    assign frame_busy = (state_d == HDR_N) || (state_d == HDR_S) ||
                        (state_d == DATA)  || (state_d == WRITE);

    // One assembler serves the N, S and data words; it is cleared between frames.
    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (accept),
        .clear     (!in_frame && !accept),
        .byte_in   (byte_in),
        .word_done (word_done),
        .word      (word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: frame parsing and header validation.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HDR_N;
            HDR_N:   if (word_done) state_d = (word > 32'(MAX_WORDS)) ? ERR : HDR_S;
            HDR_S: begin
                if (word_done) begin
                    if (word[1:0] != 2'b00) state_d = ERR;
                    else if (n_q == '0)     state_d = RELEASE;
                    else                    state_d = DATA;
                end
            end
            DATA:    if (word_done) state_d = WRITE;
            WRITE:   state_d = (idx_next == n_q) ? RELEASE : DATA;
            RELEASE: state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Header fields and the running word index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q   <= '0;
            s_q   <= '0;
            idx_q <= '0;
        end else begin
            if (state_q == HDR_N && word_done) n_q <= word[IDX_W-1:0];
            if (state_q == HDR_S && word_done) s_q <= word;
            if (state_q == HDR_S)      idx_q <= '0;
            else if (state_q == WRITE) idx_q <= idx_next;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ready    <= 1'b0;
            busy          <= 1'b0;
            freeze        <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            branchTaken   <= 1'b0;
            flush         <= 1'b0;
            branchAddress <= '0;
            error         <= 1'b0;
        end else begin
            byte_ready  <= (state_d == IDLE) || (state_d == HDR_N) ||
                           (state_d == HDR_S) || (state_d == DATA);
            busy        <= frame_busy;
            freeze      <= frame_busy;
            imem_we     <= (state_d == WRITE);
            imem_addr   <= (state_d == WRITE) ? BASE_ADDR + 32'({idx_q, 2'b00}) : '0;
            imem_wdata  <= (state_d == WRITE) ? word : '0;
            branchTaken <= (state_d == RELEASE);
            flush       <= (state_d == RELEASE);
            // A zero-length frame releases straight from HDR_S, before s_q is loaded.
            if (state_d == RELEASE) branchAddress <= (state_q == HDR_S) ? word : s_q;
            else                    branchAddress <= '0;
            if (state_d == ERR)                  error <= 1'b1;
            else if (state_q == IDLE && accept)  error <= 1'b0;
        end
    end

endmodule
